// File: rtl/qpu_exu_mwbck.sv
// Measurement write-back: collects per-qubit readout results for the oldest
// outstanding MEASURE/FMR head mask and commits them to the result register.
module qpu_exu_mwbck #(
    parameter int unsigned QUBIT_NUM = 8,
    parameter int unsigned TMO_W     = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [QUBIT_NUM-1:0] meas_i_valid,
    input  logic [QUBIT_NUM-1:0] meas_i_result,
    input  logic                 mf_vld,
    input  logic [QUBIT_NUM-1:0] ret_mf,
    output logic                 ret_qf_ena,
    output logic [QUBIT_NUM-1:0] mrf_wen,
    output logic [QUBIT_NUM-1:0] mrf_wdat,
    input  logic                 err_clr,
    output logic                 tmo_err,
    output logic                 ovf_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } state_t;

    state_t               state;
    logic [QUBIT_NUM-1:0] arrive_r;
    logic [QUBIT_NUM-1:0] res_r;
    logic [QUBIT_NUM-1:0] mask_r;
    logic [TMO_W-1:0]     tmo_cnt;

    logic [QUBIT_NUM-1:0] consume;
    logic [QUBIT_NUM-1:0] arrived;
    logic [QUBIT_NUM-1:0] merged;
    logic [QUBIT_NUM-1:0] arrive_nxt;
    logic                 done;
    logic                 tmo_hit;
    logic                 ovf_set;

    // Arrivals in the same cycle bypass the buffer so a commit never waits a
    // cycle for the last result to land in arrive_r/res_r.
    always_comb begin
        consume    = (state == COMMIT) ? mask_r : '0;
        arrived    = arrive_r | meas_i_valid;
        merged     = (res_r & ~meas_i_valid) | (meas_i_result & meas_i_valid);
        arrive_nxt = (arrive_r & ~consume) | meas_i_valid;
        done       = &(arrived | ~mask_r);
        tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT - 1));
        ovf_set    = |(meas_i_valid & arrive_r & ~consume);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            arrive_r   <= '0;
            res_r      <= '0;
            mask_r     <= '0;
            tmo_cnt    <= '0;
            ret_qf_ena <= 1'b0;
            mrf_wen    <= '0;
            mrf_wdat   <= '0;
            tmo_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            arrive_r   <= arrive_nxt;
            res_r      <= merged;
            ret_qf_ena <= 1'b0;
            mrf_wen    <= '0;
            mrf_wdat   <= '0;
            ovf_err    <= ovf_set | (ovf_err & ~err_clr);
            tmo_err    <= tmo_err & ~err_clr;

            case (state)
                IDLE: begin
                    if (mf_vld) begin
                        mask_r  <= ret_mf;
                        tmo_cnt <= '0;
                        if (ret_mf == '0) begin
                            state      <= COMMIT;
                            ret_qf_ena <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (done) begin
                        state      <= COMMIT;
                        ret_qf_ena <= 1'b1;
                        mrf_wen    <= mask_r;
                        mrf_wdat   <= merged & mask_r;
                    end else if (tmo_hit) begin
                        state      <= COMMIT;
                        ret_qf_ena <= 1'b1;
                        mrf_wen    <= mask_r & arrived;
                        mrf_wdat   <= merged & mask_r & arrived;
                        tmo_err    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_qpu_exu_mwbck.sv
// Self-checking bench for qpu_exu_mwbck: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_qpu_exu_mwbck;

    localparam int unsigned QN  = 8;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [QN-1:0] meas_i_valid = '0;
    logic [QN-1:0] meas_i_result = '0;
    logic          mf_vld = 1'b0;
    logic [QN-1:0] ret_mf = '0;
    logic          ret_qf_ena;
    logic [QN-1:0] mrf_wen;
    logic [QN-1:0] mrf_wdat;
    logic          err_clr = 1'b0;
    logic          tmo_err;
    logic          ovf_err;
    logic          busy;

    qpu_exu_mwbck #(.QUBIT_NUM(QN), .TMO_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .meas_i_valid(meas_i_valid), .meas_i_result(meas_i_result),
        .mf_vld(mf_vld), .ret_mf(ret_mf),
        .ret_qf_ena(ret_qf_ena), .mrf_wen(mrf_wen), .mrf_wdat(mrf_wdat),
        .err_clr(err_clr), .tmo_err(tmo_err), .ovf_err(ovf_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 waiting for a head, 1 gathering results, 2 popping.
    int      m_phase = 0;
    int      m_wait = 0;
    bit [7:0] m_mask = '0;
    bit [7:0] m_arr = '0;
    bit [7:0] m_res = '0;
    bit      exp_pop = 1'b0;
    bit [7:0] exp_wen = '0;
    bit [7:0] exp_wdat = '0;
    bit      exp_tmo = 1'b0;
    bit      exp_ovf = 1'b0;
    bit      exp_busy = 1'b0;

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_mask = '0; m_arr = '0; m_res = '0;
        exp_pop = 0; exp_wen = '0; exp_wdat = '0; exp_tmo = 0; exp_ovf = 0; exp_busy = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        bit [7:0] consumed, have, merged;
        bit ovf_hit, tmo_hit;
        if (!rst_n) begin
            model_reset();
        end else begin
            ovf_hit = 0;
            tmo_hit = 0;
            for (int j = 0; j < 8; j++) begin
                consumed[j] = (m_phase == 2) && m_mask[j];
                have[j]     = m_arr[j] || meas_i_valid[j];
                merged[j]   = meas_i_valid[j] ? meas_i_result[j] : m_res[j];
                if (meas_i_valid[j] && m_arr[j] && !consumed[j]) ovf_hit = 1;
            end
            exp_pop = 0; exp_wen = '0; exp_wdat = '0;
            if (m_phase == 0) begin
                if (mf_vld) begin
                    m_mask = ret_mf;
                    m_wait = 0;
                    if (ret_mf == 8'h00) begin m_phase = 2; exp_pop = 1; end
                    else m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if ((have & m_mask) == m_mask) begin
                    m_phase = 2; exp_pop = 1;
                    exp_wen = m_mask; exp_wdat = merged & m_mask;
                end else if (m_wait == TMO - 1) begin
                    m_phase = 2; exp_pop = 1; tmo_hit = 1;
                    exp_wen = m_mask & have; exp_wdat = merged & exp_wen;
                end else begin
                    m_wait++;
                end
            end else begin
                m_phase = 0;
            end
            for (int j = 0; j < 8; j++) begin
                if (meas_i_valid[j]) begin m_arr[j] = 1; m_res[j] = meas_i_result[j]; end
                else if (consumed[j]) m_arr[j] = 0;
            end
            exp_tmo  = tmo_hit || (exp_tmo && !err_clr);
            exp_ovf  = ovf_hit || (exp_ovf && !err_clr);
            exp_busy = (m_phase != 0);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp("ret_qf_ena", 32'(ret_qf_ena), 32'(exp_pop));
            cmp("mrf_wen", 32'(mrf_wen), 32'(exp_wen));
            cmp("mrf_wdat", 32'(mrf_wdat), 32'(exp_wdat));
            cmp("tmo_err", 32'(tmo_err), 32'(exp_tmo));
            cmp("ovf_err", 32'(ovf_err), 32'(exp_ovf));
            cmp("busy", 32'(busy), 32'(exp_busy));
        end
    end

    // Measurement FIFO stand-in; pops follow the model's pop, one cycle late.
    logic [7:0] q[$];
    bit pop_pend = 0;

    task automatic drive_head();
        mf_vld = (q.size() != 0);
        ret_mf = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pend && q.size() != 0) void'(q.pop_front());
        pop_pend = exp_pop;
        meas_i_valid = '0;
        meas_i_result = '0;
        err_clr = 1'b0;
        drive_head();
    endtask

    task automatic push(input logic [7:0] m);
        q.push_back(m);
        drive_head();
    endtask

    task automatic res(input int j, input bit v);
        meas_i_valid[j] = 1'b1;
        meas_i_result[j] = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        check_en = 1'b1;
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_wen", 32'(mrf_wen), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Head 0x05, q0=1 at cycle 3, q2=0 at cycle 5, commit at cycle 6.
        push(8'h05);
        idle(3);
        res(0, 1'b1);
        idle(2);
        res(2, 1'b0);
        cmp("t1_pop_c5", 32'(ret_qf_ena), 32'd0);
        tick();
        cmp("t1_pop_c6", 32'(ret_qf_ena), 32'd1);
        cmp("t1_model_pop", 32'(exp_pop), 32'd1);
        cmp("t1_wen", 32'(mrf_wen), 32'h05);
        cmp("t1_wdat", 32'(mrf_wdat), 32'h01);
        tick();
        cmp("t1_pop_c7", 32'(ret_qf_ena), 32'd0);
        cmp("t1_wen_c7", 32'(mrf_wen), 32'd0);
        idle(3);

        // Results buffered before head 0x0A.
        res(1, 1'b1); res(3, 1'b1);
        tick();
        push(8'h0A);
        tick();
        cmp("t2_busy", 32'(busy), 32'd1);
        cmp("t2_pop_c1", 32'(ret_qf_ena), 32'd0);
        tick();
        cmp("t2_pop_c2", 32'(ret_qf_ena), 32'd1);
        cmp("t2_wen", 32'(mrf_wen), 32'h0A);
        cmp("t2_wdat", 32'(mrf_wdat), 32'h0A);
        cmp("t2_errs", 32'({tmo_err, ovf_err}), 32'd0);
        idle(3);

        // Timeout: head 0x03, only q0 returns.
        push(8'h03);
        tick();
        tick();
        res(0, 1'b1);
        for (int c = 3; c <= 16; c++) tick();
        cmp("t3_pop_c16", 32'(ret_qf_ena), 32'd0);
        tick();
        cmp("t3_pop_c17", 32'(ret_qf_ena), 32'd1);
        cmp("t3_wen", 32'(mrf_wen), 32'h01);
        cmp("t3_wdat", 32'(mrf_wdat), 32'h01);
        cmp("t3_tmo", 32'(tmo_err), 32'd1);
        cmp("t3_model_tmo", 32'(exp_tmo), 32'd1);
        idle(4);
        cmp("t3_tmo_sticky", 32'(tmo_err), 32'd1);
        err_clr = 1'b1;
        tick();
        cmp("t3_tmo_clr", 32'(tmo_err), 32'd0);
        idle(2);

        // Back-to-back heads; second result arrives in the first COMMIT cycle.
        push(8'h01); push(8'h01);
        tick();
        res(0, 1'b0);
        tick();
        cmp("t4_pop1", 32'(ret_qf_ena), 32'd1);
        cmp("t4_wdat1", 32'(mrf_wdat), 32'h00);
        res(0, 1'b1);
        idle(3);
        cmp("t4_pop2", 32'(ret_qf_ena), 32'd1);
        cmp("t4_wen2", 32'(mrf_wen), 32'h01);
        cmp("t4_wdat2", 32'(mrf_wdat), 32'h01);
        cmp("t4_ovf", 32'(ovf_err), 32'd0);
        idle(3);

        // Double q4 pulse, then commit; then a zero-mask head.
        res(4, 1'b0);
        tick();
        res(4, 1'b1);
        tick();
        cmp("t5_ovf", 32'(ovf_err), 32'd1);
        push(8'h10);
        idle(2);
        cmp("t5_wen", 32'(mrf_wen), 32'h10);
        cmp("t5_wdat", 32'(mrf_wdat), 32'h10);
        err_clr = 1'b1;
        idle(3);
        cmp("t5_ovf_clr", 32'(ovf_err), 32'd0);
        push(8'h00);
        tick();
        cmp("t5_zpop", 32'(ret_qf_ena), 32'd1);
        cmp("t5_zwen", 32'(mrf_wen), 32'h00);
        tick();
        cmp("t5_zpop_off", 32'(ret_qf_ena), 32'd0);
        idle(3);

        // Reset during COLLECT with a partial buffer; the same head recommits.
        err_clr = 1'b0;
        push(8'h03);
        tick();
        res(0, 1'b1);
        tick();
        rst_n = 1'b0;
        pop_pend = 0;
        #1;
        cmp("t6_outs", 32'({ret_qf_ena, mrf_wen, mrf_wdat, tmo_err, ovf_err, busy}), 32'd0);
        tick();
        pop_pend = 0;
        cmp("t6_nopop", 32'(ret_qf_ena), 32'd0);
        rst_n = 1'b1;
        res(0, 1'b1); res(1, 1'b0);
        idle(2);
        cmp("t6_pop", 32'(ret_qf_ena), 32'd1);
        cmp("t6_wen", 32'(mrf_wen), 32'h03);
        cmp("t6_wdat", 32'(mrf_wdat), 32'h01);
        idle(3);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (q.size() < 3 && $urandom_range(0, 5) == 0)
                push(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom));
            for (int j = 0; j < 8; j++)
                if ($urandom_range(0, 9) == 0) res(j, 1'($urandom));
            err_clr = ($urandom_range(0, 49) == 0);
            tick();
        end
        q.delete();
        idle(TMO + 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
